// File: rtl/expr_vector_sequencer_pkg.sv
// Shared types, widths and signature arithmetic for the expression vector sequencer.
// Holds the FSM state encoding and the y-fold / MISR helpers used by the top.
package expr_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CAPTURE,
        ST_DONE
    } seq_state_t;

    localparam int A_W = 30;
    localparam int B_W = 30;
    localparam int Y_W = 90;

    localparam logic [31:0] MISR_POLY = 32'h04C1_1DB7;
    localparam logic [31:0] SIG_INIT  = 32'hFFFF_FFFF;

    // y is zero-extended to three whole 32-bit words before folding.
    function automatic logic [31:0] fold90(input logic [Y_W-1:0] y);
        logic [95:0] y96;
        y96 = 96'(y);
        return y96[95:64] ^ y96[63:32] ^ y96[31:0];
    endfunction

    function automatic logic [31:0] misr_step(input logic [31:0] sig, input logic [Y_W-1:0] y);
        return {sig[30:0], 1'b0} ^ (sig[31] ? MISR_POLY : 32'h0) ^ fold90(y);
    endfunction

endpackage

// File: rtl/expr_vector_sequencer_if.sv
// Host/datapath-facing bundle of the sequencer: run handshake, operand vectors,
// datapath result and the running signature.
interface expr_vector_sequencer_if;
    import expr_seq_pkg::*;

    logic             start;
    logic             abort;
    logic             busy;
    logic             done;
    logic [15:0]      vec_count;
    logic [A_W-1:0]   opd_a;
    logic [B_W-1:0]   opd_b;
    logic [Y_W-1:0]   res_y;
    logic [31:0]      signature;

    // Host and datapath side.
    modport master (
        output start, abort, res_y,
        input  busy, done, vec_count, opd_a, opd_b, signature
    );

    // Sequencer side.
    modport slave (
        input  start, abort, res_y,
        output busy, done, vec_count, opd_a, opd_b, signature
    );

endinterface

// File: rtl/expr_lfsr64.sv
// 64-bit Fibonacci LFSR (taps 64,63,61,60) with seed load, step enable and a
// guard that replaces an all-zero seed by 1 so the register can never lock up.
module expr_lfsr64 #(
    parameter logic [63:0] SEED = 64'h0000_0000_0000_0001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    output logic [63:0] state_next
);

    localparam logic [63:0] SEED_SAFE = (SEED == 64'h0) ? 64'h1 : SEED;

    logic [63:0] state;
    logic        feedback;

    always_comb begin
        feedback   = state[63] ^ state[62] ^ state[60] ^ state[59];
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        state_next = state;
        if (load) begin
            state_next = SEED_SAFE;
        end else if (step) begin
            state_next = {state[62:0], feedback};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SEED_SAFE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all flops update together.
            state <= state_next;
        end
    end

endmodule

// File: rtl/expr_vector_sequencer.sv
// Self-test controller: drives LFSR operand vectors into an expression datapath,
// holds each for a settle time, captures y into a MISR and counts vectors.
module expr_vector_sequencer
    import expr_seq_pkg::*;
#(
    parameter int          NUM_VECTORS = 256,
    parameter int          SETTLE      = 2,
    parameter logic [63:0] SEED        = 64'h0000_0000_0000_0001
) (
    input  logic                  clk,
    input  logic                  rst,
    expr_vector_sequencer_if.slave bus
);

    localparam logic [15:0] LAST_COUNT  = 16'(NUM_VECTORS);
    localparam logic [3:0]  SETTLE_LOAD = 4'(SETTLE - 1);

    seq_state_t  state;
    logic [3:0]  settle_cnt;
    logic [15:0] count_inc;
    logic        last_capture;
    logic        lfsr_load;
    logic        lfsr_step;
    logic [63:0] lfsr_next;

    assign count_inc    = bus.vec_count + 16'd1;
    assign last_capture = (count_inc == LAST_COUNT);

    // The final capture of a run leaves the LFSR alone so the operands stay on the last vector.
    always_comb begin
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: lfsr_load = bus.start;
            ST_CAPTURE:       lfsr_step = !last_capture;
            default:          ;
        endcase
    end

    expr_lfsr64 #(.SEED(SEED)) u_lfsr (
        .clk        (clk),
        .rst        (rst),
        .load       (lfsr_load),
        .step       (lfsr_step),
        .state_next (lfsr_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            settle_cnt    <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.vec_count <= '0;
            bus.signature <= '0;
            bus.opd_a     <= '0;
            bus.opd_b     <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        state         <= ST_SETTLE;
                        settle_cnt    <= SETTLE_LOAD;
                        bus.busy      <= 1'b1;
                        bus.done      <= 1'b0;
                        bus.vec_count <= '0;
                        bus.signature <= SIG_INIT;
                    end
                end
                ST_SETTLE: begin
                    if (bus.abort) begin
                        state    <= ST_IDLE;
                        bus.busy <= 1'b0;
                    end else if (settle_cnt == 4'd0) begin
                        state <= ST_CAPTURE;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                ST_CAPTURE: begin
                    // An aborted capture cycle still records its vector.
                    bus.signature <= misr_step(bus.signature, bus.res_y);
                    bus.vec_count <= count_inc;
                    settle_cnt    <= SETTLE_LOAD;
                    if (bus.abort) begin
                        state    <= ST_IDLE;
                        bus.busy <= 1'b0;
                    end else if (last_capture) begin
                        state    <= ST_DONE;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                    end else begin
                        state <= ST_SETTLE;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                end
            endcase

            if (lfsr_load || lfsr_step) begin
                bus.opd_a <= lfsr_next[A_W+B_W-1:B_W];
                bus.opd_b <= lfsr_next[B_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_expr_vector_sequencer.sv
// Scoreboard bench for expr_vector_sequencer: four instances with different
// parameters; stimulus queues expected run results, one monitor compares them.
module tb_expr_vector_sequencer;

    localparam int          N_DUT      = 4;
    localparam int          NV_T   [4] = '{1, 1, 4, 256};
    localparam int          ST_T   [4] = '{1, 1, 3, 2};
    localparam logic [63:0] SEED_T [4] = '{64'h1, 64'h0, 64'h0123_4567_89AB_CDEF,
                                           64'h9E37_79B9_7F4A_7C15};

    typedef struct {
        logic        done;
        logic [15:0] cnt;
        logic [31:0] sig;
        logic [59:0] opd;
        int          len;   // busy cycles of the run, -1 when not checked
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_v [N_DUT];
    logic        abort_v [N_DUT];
    logic        busy_v  [N_DUT];
    logic        done_v  [N_DUT];
    logic [15:0] cnt_v   [N_DUT];
    logic [29:0] a_v     [N_DUT];
    logic [29:0] b_v     [N_DUT];
    logic [31:0] sig_v   [N_DUT];

    exp_t        rq [N_DUT][$];
    logic [59:0] vq [N_DUT][$];

    int total = 0;
    int bad   = 0;
    bit end_req = 1'b0;

    always #5 clk = ~clk;

    // ---------------- reference models ----------------
    function automatic logic [63:0] m_step(input logic [63:0] l);
        return {l[62:0], l[63] ^ l[62] ^ l[60] ^ l[59]};
    endfunction

    function automatic logic [31:0] m_misr(input logic [31:0] s, input logic [89:0] y);
        logic [31:0] f;
        f = {6'h0, y[89:64]} ^ y[63:32] ^ y[31:0];
        return {s[30:0], 1'b0} ^ (s[31] ? 32'h04C1_1DB7 : 32'h0) ^ f;
    endfunction

    // Golden expression attached to the last instance.
    function automatic logic [89:0] expr_y(input logic [29:0] a, input logic [29:0] b);
        return {a ^ b, 60'(a) * 60'(b)};
    endfunction

    function automatic exp_t model(input logic [63:0] seed, input int n, input int nv,
                                   input bit use_expr, input bit fin, input int len);
        exp_t        e;
        logic [63:0] l;
        logic [31:0] s;
        logic [89:0] y;
        l = (seed == 64'h0) ? 64'h1 : seed;
        s = 32'hFFFF_FFFF;
        for (int k = 0; k < n; k++) begin
            y = use_expr ? expr_y(l[59:30], l[29:0]) : 90'h0;
            s = m_misr(s, y);
            if (k + 1 != nv) l = m_step(l);
        end
        e.done = fin;
        e.cnt  = 16'(n);
        e.sig  = s;
        e.opd  = l[59:0];
        e.len  = len;
        return e;
    endfunction

    // ---------------- DUT instances ----------------
    for (genvar g = 0; g < N_DUT; g++) begin : gen_dut
        expr_vector_sequencer_if bus ();

        assign bus.start = start_v[g];
        assign bus.abort = abort_v[g];
        if (g == N_DUT - 1) begin : gen_expr
            assign bus.res_y = expr_y(bus.opd_a, bus.opd_b);
        end else begin : gen_zero
            assign bus.res_y = '0;
        end
        assign busy_v[g] = bus.busy;
        assign done_v[g] = bus.done;
        assign cnt_v[g]  = bus.vec_count;
        assign a_v[g]    = bus.opd_a;
        assign b_v[g]    = bus.opd_b;
        assign sig_v[g]  = bus.signature;

        expr_vector_sequencer #(
            .NUM_VECTORS (NV_T[g]),
            .SETTLE      (ST_T[g]),
            .SEED        (SEED_T[g])
        ) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input int idx, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d: got=%0h want=%0h at %0t", name, idx, act, exp, $time);
        end
    endtask

    bit          first = 1'b1;
    bit          end_done = 1'b0;
    logic        busy_prev [N_DUT];
    logic [59:0] opd_prev  [N_DUT];
    int          hold      [N_DUT];
    int          hold_exp  [N_DUT];
    int          blen      [N_DUT];

    always @(negedge clk) begin
        logic [59:0] cur;
        logic        new_vec;
        logic        vec_end;
        exp_t        e;
        for (int i = 0; i < N_DUT; i++) begin
            cur = {a_v[i], b_v[i]};
            if (first) begin
                check("reset_busy", i, 64'(busy_v[i]), 64'h0);
                check("reset_done", i, 64'(done_v[i]), 64'h0);
                check("reset_count", i, 64'(cnt_v[i]), 64'h0);
                check("reset_sig", i, 64'(sig_v[i]), 64'h0);
                check("reset_opd", i, 64'(cur), 64'h0);
                busy_prev[i] = 1'b0;
                opd_prev[i]  = '0;
                hold[i]      = 0;
                hold_exp[i]  = 0;
                blen[i]      = 0;
            end else begin
                if (busy_v[i] && !busy_prev[i]) begin
                    check("start_done_clr", i, 64'(done_v[i]), 64'h0);
                    check("start_count", i, 64'(cnt_v[i]), 64'h0);
                    check("start_sig", i, 64'(sig_v[i]), 64'hFFFF_FFFF);
                    blen[i] = 0;
                end
                new_vec = busy_v[i] && (!busy_prev[i] || cur != opd_prev[i]);
                vec_end = busy_prev[i] && (!busy_v[i] || new_vec);
                if (vec_end && hold_exp[i] != 0) begin
                    check("vec_hold", i, 64'(hold[i]), 64'(hold_exp[i]));
                    hold_exp[i] = 0;
                end
                if (new_vec) begin
                    hold[i] = 0;
                    if (vq[i].size() != 0) begin
                        check("vec_value", i, 64'(cur), 64'(vq[i].pop_front()));
                        hold_exp[i] = ST_T[i] + 1;
                    end
                end
                if (busy_v[i]) begin
                    hold[i]++;
                    blen[i]++;
                end
                if (!busy_v[i] && busy_prev[i]) begin
                    check("run_expected", i, 64'(rq[i].size() != 0), 64'h1);
                    if (rq[i].size() != 0) begin
                        e = rq[i].pop_front();
                        check("end_done", i, 64'(done_v[i]), 64'(e.done));
                        check("end_count", i, 64'(cnt_v[i]), 64'(e.cnt));
                        check("end_sig", i, 64'(sig_v[i]), 64'(e.sig));
                        check("end_opd", i, 64'(cur), 64'(e.opd));
                        if (e.len >= 0) check("run_len", i, 64'(blen[i]), 64'(e.len));
                    end
                end
                busy_prev[i] = busy_v[i];
                opd_prev[i]  = cur;
            end
        end
        first = 1'b0;
        if (end_req && !end_done) begin
            for (int i = 0; i < N_DUT; i++) begin
                check("runs_left", i, 64'(rq[i].size()), 64'h0);
                check("vecs_left", i, 64'(vq[i].size()), 64'h0);
            end
            end_done = 1'b1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic pulse_start(input int i);
        @(posedge clk);
        #1 start_v[i] = 1'b1;
        @(posedge clk);
        #1 start_v[i] = 1'b0;
    endtask

    task automatic wait_end(input int i, input int bound);
        for (int k = 0; k < bound && busy_v[i]; k++) begin
            @(posedge clk);
            #1;
        end
        repeat (2) @(posedge clk);
    endtask

    initial begin
        exp_t        e;
        logic [63:0] l;
        for (int i = 0; i < N_DUT; i++) begin
            start_v[i] = 1'b0;
            abort_v[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Single vector, y = 0: hand-computed MISR of SIG_INIT with a zero fold.
        for (int i = 0; i < 2; i++) begin
            vq[i].push_back(60'h1);
            e = '{done: 1'b1, cnt: 16'd1, sig: 32'hFB3E_E249, opd: 60'h1, len: 2};
            rq[i].push_back(e);
            pulse_start(i);
            wait_end(i, 20);
        end

        // Four vectors held four cycles each.
        l = SEED_T[2];
        for (int k = 0; k < 4; k++) begin
            vq[2].push_back(l[59:0]);
            l = m_step(l);
        end
        rq[2].push_back(model(SEED_T[2], 4, 4, 1'b0, 1'b1, 16));
        pulse_start(2);
        wait_end(2, 40);

        // Full run through the golden expression, with a start pulse while busy.
        rq[3].push_back(model(SEED_T[3], 256, 256, 1'b1, 1'b1, 768));
        pulse_start(3);
        repeat (50) @(posedge clk);
        pulse_start(3);
        wait_end(3, 1000);

        // Restart straight from DONE must reproduce the signature.
        rq[3].push_back(model(SEED_T[3], 256, 256, 1'b1, 1'b1, 768));
        pulse_start(3);
        wait_end(3, 1000);

        // Abort in the third vector's settle phase.
        rq[3].push_back(model(SEED_T[3], 2, 256, 1'b1, 1'b0, 7));
        pulse_start(3);
        repeat (6) @(posedge clk);
        #1 abort_v[3] = 1'b1;
        @(posedge clk);
        #1 abort_v[3] = 1'b0;
        repeat (3) @(posedge clk);

        // Reset between clock edges mid-run clears everything at once.
        e = '{done: 1'b0, cnt: 16'd0, sig: 32'h0, opd: 60'h0, len: -1};
        rq[3].push_back(e);
        pulse_start(3);
        repeat (20) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);

        rq[3].push_back(model(SEED_T[3], 256, 256, 1'b1, 1'b1, 768));
        pulse_start(3);
        wait_end(3, 1000);

        end_req = 1'b1;
        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
